// File: rtl/axi4_lite_master_adaptor_if.sv
// AXI4-Lite channel bundle between axi4_lite_master_adaptor and a downstream slave.
interface axi4_lite_master_adaptor_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr_out;
  logic [2:0]            awprot_out;
  logic                  awvalid_out;
  logic                  awready_in;
  logic [DATA_WIDTH-1:0] wdata_out;
  logic [STRB_WIDTH-1:0] wstrb_out;
  logic                  wvalid_out;
  logic                  wready_in;
  logic [1:0]            bresp_in;
  logic                  bvalid_in;
  logic                  bready_out;
  logic [ADDR_WIDTH-1:0] araddr_out;
  logic [2:0]            arprot_out;
  logic                  arvalid_out;
  logic                  arready_in;
  logic [DATA_WIDTH-1:0] rdata_in;
  logic [1:0]            rresp_in;
  logic                  rvalid_in;
  logic                  rready_out;

  modport master (
    output awaddr_out, awprot_out, awvalid_out, input awready_in,
    output wdata_out, wstrb_out, wvalid_out, input wready_in,
    input  bresp_in, bvalid_in, output bready_out,
    output araddr_out, arprot_out, arvalid_out, input arready_in,
    input  rdata_in, rresp_in, rvalid_in, output rready_out
  );

  modport slave (
    input  awaddr_out, awprot_out, awvalid_out, output awready_in,
    input  wdata_out, wstrb_out, wvalid_out, output wready_in,
    output bresp_in, bvalid_in, input bready_out,
    input  araddr_out, arprot_out, arvalid_out, output arready_in,
    output rdata_in, rresp_in, rvalid_in, input rready_out
  );
endinterface

// File: rtl/axi4_lite_master_adaptor.sv
// Single-outstanding AXI4-Lite master: local write/read commands to AXI channel traffic.
// Optional watchdog abort enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master_adaptor #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      wr_start_in,
  input  logic                      rd_start_in,
  input  logic [ADDR_WIDTH-1:0]     addr_in,
  input  logic [2:0]                prot_in,
  input  logic [DATA_WIDTH-1:0]     wdata_in,
  input  logic [DATA_WIDTH/8-1:0]   wstrb_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [1:0]                resp_out,
  output logic [DATA_WIDTH-1:0]     rdata_out,
  axi4_lite_master_adaptor_if.master axi
`ifdef AXI_MASTER_TIMEOUT_EN
  ,
  output logic                      timeout_out
`endif
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t state;

  // Watchdog limit must leave room for at least one waiting cycle
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
  assign aw_hs_c = axi.awvalid_out & axi.awready_in;
  assign w_hs_c  = axi.wvalid_out  & axi.wready_in;
  assign b_hs_c  = axi.bvalid_in   & axi.bready_out;
  assign ar_hs_c = axi.arvalid_out & axi.arready_in;
  assign r_hs_c  = axi.rvalid_in   & axi.rready_out;

  // A channel is finished once its valid is low or is handshaking this cycle
  logic aw_fin_c, w_fin_c;
  assign aw_fin_c = ~axi.awvalid_out | axi.awready_in;
  assign w_fin_c  = ~axi.wvalid_out  | axi.wready_in;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt;
  logic any_hs_c, timeout_hit_c;
  assign any_hs_c      = aw_hs_c | w_hs_c | b_hs_c | ar_hs_c | r_hs_c;
  assign timeout_hit_c = (state != IDLE) && !any_hs_c &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      resp_out        <= 2'b00;
      rdata_out       <= '0;
      axi.awaddr_out  <= '0;
      axi.awprot_out  <= 3'b000;
      axi.awvalid_out <= 1'b0;
      axi.wdata_out   <= '0;
      axi.wstrb_out   <= '0;
      axi.wvalid_out  <= 1'b0;
      axi.bready_out  <= 1'b0;
      axi.araddr_out  <= '0;
      axi.arprot_out  <= 3'b000;
      axi.arvalid_out <= 1'b0;
      axi.rready_out  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt         <= '0;
      timeout_out     <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start_in) begin
            axi.awaddr_out  <= addr_in;
            axi.awprot_out  <= prot_in;
            axi.wdata_out   <= wdata_in;
            axi.wstrb_out   <= wstrb_in;
            axi.awvalid_out <= 1'b1;
            axi.wvalid_out  <= 1'b1;
            busy_out        <= 1'b1;
            state           <= WR_ADDR_DATA;
          end else if (rd_start_in) begin
            axi.araddr_out  <= addr_in;
            axi.arprot_out  <= prot_in;
            axi.arvalid_out <= 1'b1;
            busy_out        <= 1'b1;
            state           <= RD_ADDR;
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs_c) axi.awvalid_out <= 1'b0;
          if (w_hs_c)  axi.wvalid_out  <= 1'b0;
          if (aw_fin_c && w_fin_c) begin
            axi.bready_out <= 1'b1;
            state          <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs_c) begin
            axi.bready_out <= 1'b0;
            resp_out       <= axi.bresp_in;
            done_out       <= 1'b1;
            busy_out       <= 1'b0;
            state          <= IDLE;
          end
        end
        RD_ADDR: begin
          if (ar_hs_c) begin
            axi.arvalid_out <= 1'b0;
            axi.rready_out  <= 1'b1;
            state           <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs_c) begin
            rdata_out      <= axi.rdata_in;
            resp_out       <= axi.rresp_in;
            axi.rready_out <= 1'b0;
            done_out       <= 1'b1;
            busy_out       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_MASTER_TIMEOUT_EN
      // Watchdog: counts idle waiting cycles, abort overrides the case above
      if (state == IDLE || any_hs_c || timeout_hit_c) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (timeout_hit_c) begin
        axi.awvalid_out <= 1'b0;
        axi.wvalid_out  <= 1'b0;
        axi.bready_out  <= 1'b0;
        axi.arvalid_out <= 1'b0;
        axi.rready_out  <= 1'b0;
        resp_out        <= 2'b11;
        done_out        <= 1'b1;
        busy_out        <= 1'b0;
        timeout_out     <= 1'b1;
        state           <= IDLE;
      end
`endif
    end
  end

endmodule

// File: doc/axi4_lite_master_adaptor.md
Name: axi4_lite_master_adaptor

Overview:
AXI4-Lite master that turns single-word local write/read commands into AXI4-Lite channel traffic. It sits directly upstream of axi4_lite_slave_adaptor and drives its five channels. One outstanding transaction at a time. Completion is reported with a one-cycle done pulse carrying the response code and, for reads, the read data.

Parameters:
ADDR_WIDTH, 32, width of addr_in, awaddr_out and araddr_out
DATA_WIDTH, 32, width of the data buses; wstrb width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when AXI_MASTER_TIMEOUT_EN is defined

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
wr_start_in  in  1  request a write; sampled in IDLE only
rd_start_in  in  1  request a read; sampled in IDLE only
addr_in  in  ADDR_WIDTH  command address
prot_in  in  3  command protection bits
wdata_in  in  DATA_WIDTH  write data
wstrb_in  in  DATA_WIDTH/8  write byte strobes
busy_out  out  1  high while not in IDLE
done_out  out  1  one-cycle completion pulse
resp_out  out  2  BRESP or RRESP of the completed transaction
rdata_out  out  DATA_WIDTH  read data, valid from done_out onward
awaddr_out, awprot_out, awvalid_out, awready_in  AW channel (ADDR_WIDTH, 3, 1 out; 1 in)
wdata_out, wstrb_out, wvalid_out, wready_in  W channel (DATA_WIDTH, DATA_WIDTH/8, 1 out; 1 in)
bresp_in, bvalid_in, bready_out  B channel (2, 1 in; 1 out)
araddr_out, arprot_out, arvalid_out, arready_in  AR channel (ADDR_WIDTH, 3, 1 out; 1 in)
rdata_in, rresp_in, rvalid_in, rready_out  R channel (DATA_WIDTH, 2, 1 in; 1 out)

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; timeout flag 0.
- The reset is asynchronous. If it asserts mid-transaction, all valid and ready outputs drop immediately and no done_out pulse is produced.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - On wr_start_in, register addr, prot, wdata and wstrb onto the AW/W outputs. Set awvalid_out=1 and wvalid_out=1 in the next cycle. Go to WR_ADDR_DATA.
  - On rd_start_in, register addr and prot onto the AR outputs. Set arvalid_out=1. Go to RD_ADDR.
  - If both are asserted in the same cycle, the write wins and the read request is dropped.
- WR_ADDR_DATA:
  - awvalid_out clears on the cycle after awvalid&awready. wvalid_out clears on the cycle after wvalid&wready. The two handshakes are independent and may occur in either order or in the same cycle.
  - Once both handshakes have completed, set bready_out=1 and go to WR_RESP. Addr/data outputs stay stable while their valid is high.
- WR_RESP: on bvalid_in&bready_out, clear bready_out, set resp_out=bresp_in, pulse done_out for one cycle, return to IDLE.
- RD_ADDR: on arvalid&arready, clear arvalid_out, set rready_out=1, go to RD_DATA.
- RD_DATA: on rvalid_in&rready_out, capture rdata_in into rdata_out and rresp_in into resp_out, clear rready_out, pulse done_out, return to IDLE.
- No valid output drops before its handshake completes. Valid outputs never depend combinationally on any ready input.
- Minimum latency with zero-wait slave: write is start, then AW/W handshake at +1, B handshake at +2, done at +3; read is start, AR at +1, R at +2, done at +3.
- Start inputs outside IDLE are ignored. A new command is accepted in the cycle done_out is high, because the FSM is already in IDLE.
- resp_out and rdata_out hold their values until the next completion.

Optional Feature:
AXI_MASTER_TIMEOUT_EN:
- Defined:
  - A counter runs in every non-IDLE state and resets on any handshake or state change.
  - When it reaches TIMEOUT_CYCLES, all valid and ready outputs clear, resp_out=2'b11, done_out pulses, and the FSM returns to IDLE.
  - An extra output timeout_out (1 bit) goes high and stays high (sticky) until reset.
- Not defined: no counter and no timeout_out port; the FSM waits indefinitely.

Test Plan:
- Write, slave ready immediately: addr=16, wdata=F0B4A596, wstrb=1011, prot=4 -> awvalid/wvalid high for 1 cycle with those values; done_out at start+3 with resp_out=00.
- Write, wready delayed 4 cycles after awready -> awvalid drops after its handshake, wvalid holds for 4 more cycles, bready rises only after the W handshake; done with bresp=10 gives resp_out=10.
- Read, addr=16, slave returns rdata=F0B4A596 with rvalid 3 cycles after AR -> rdata_out=F0B4A596, resp_out=00, done_out high exactly 1 cycle.
- wr_start_in and rd_start_in both high in IDLE -> only AW/W traffic; arvalid_out stays 0.
- aresetn low while in WR_RESP -> bready_out=0 immediately, no done_out pulse; a following read completes normally.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, arready held at 0 -> arvalid_out drops after 8 cycles, resp_out=11, done_out pulses, timeout_out stays 1.
